// File: rtl/eviction_writeback_ctrl_pkg.sv
// Shared definitions for the dirty-line writeback path between the cache controller and pmem.
package eviction_writeback_ctrl_pkg;

  localparam int LINE_ADDR_W = 12;
  localparam int OFFSET_W    = 4;
  localparam int DATA_W      = 128;
  localparam int BYTE_ADDR_W = LINE_ADDR_W + OFFSET_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } wb_state_t;

  function automatic logic [BYTE_ADDR_W-1:0] line_to_byte(input logic [LINE_ADDR_W-1:0] line);
    return {line, {OFFSET_W{1'b0}}};
  endfunction

endpackage

// File: rtl/eviction_writeback_ctrl.sv
// Parks one dirty line in the external eviction buffer, lets the pending fill go first,
// serves fills that hit the parked line, and drains it to pmem when the port is free.
module eviction_writeback_ctrl
  import eviction_writeback_ctrl_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   evict_req,
  input  logic [LINE_ADDR_W-1:0] evict_addr,
  input  logic [DATA_W-1:0]      evict_data,
  output logic                   evict_ack,
  input  logic                   mem_read,
  input  logic [LINE_ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0]      mem_rdata,
  output logic                   mem_resp,
  output logic                   evb_load,
  input  logic [LINE_ADDR_W-1:0] evb_addr,
  input  logic [DATA_W-1:0]      evb_data,
  output logic                   pmem_read,
  output logic                   pmem_write,
  output logic [BYTE_ADDR_W-1:0] pmem_address,
  output logic [DATA_W-1:0]      pmem_wdata,
  input  logic [DATA_W-1:0]      pmem_rdata,
  input  logic                   pmem_resp,
  output logic                   wb_idle,
  output logic [15:0]            wb_count
);

  wb_state_t   state_q, state_d;
  logic        buf_valid_q, buf_valid_d;
  logic [15:0] wb_count_q, wb_count_d;
  logic        rst_dly_q;
  logic        quiet, accept, hit;
  logic        unused_evict_data;

  // evict_data is wired straight into the parent's buffer; only the load strobe comes from here.
  assign unused_evict_data = ^evict_data;

  always_comb begin
    quiet       = rst | rst_dly_q;
    accept      = ~quiet & evict_req & ~buf_valid_q & (state_q != WRITE);
    hit         = (state_q == IDLE) & mem_read & buf_valid_q & (mem_addr == evb_addr);
    state_d     = state_q;
    buf_valid_d = buf_valid_q | accept;
    wb_count_d  = wb_count_q;
    mem_resp     = 1'b0;
    mem_rdata    = '0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    unique case (state_q)
      IDLE: begin
        if (hit) begin
          mem_resp  = 1'b1;
          mem_rdata = evb_data;
        end else if (mem_read) begin
          state_d = READ;
        end else if (buf_valid_q) begin
          state_d = WRITE;
        end
      end
      READ: begin
        pmem_read    = 1'b1;
        pmem_address = line_to_byte(mem_addr);
        if (pmem_resp) begin
          mem_resp  = 1'b1;
          mem_rdata = pmem_rdata;
          state_d   = IDLE;
        end
      end
      WRITE: begin
        pmem_write   = 1'b1;
        pmem_address = line_to_byte(evb_addr);
        if (pmem_resp) begin
          buf_valid_d = 1'b0;
          wb_count_d  = (wb_count_q == 16'hFFFF) ? wb_count_q : wb_count_q + 16'd1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Hold every strobe low through the reset cycle and the one after it.
    if (quiet) begin
      mem_resp     = 1'b0;
      mem_rdata    = '0;
      pmem_read    = 1'b0;
      pmem_write   = 1'b0;
      pmem_address = '0;
    end
  end

  assign evict_ack  = accept;
  assign evb_load   = accept;
  assign pmem_wdata = quiet ? '0 : evb_data;
  assign wb_idle    = quiet | ((state_q == IDLE) & ~buf_valid_q);
  assign wb_count   = quiet ? '0 : wb_count_q;

  always_ff @(posedge clk) begin
    rst_dly_q <= rst;
    if (rst) begin
      state_q     <= IDLE;
      buf_valid_q <= 1'b0;
      wb_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      buf_valid_q <= buf_valid_d;
      wb_count_q  <= wb_count_d;
    end
  end

  a_no_evict_read_alias: assert property (@(posedge clk) disable iff (rst)
    !(accept && mem_read && (mem_addr == evict_addr)));

  a_pmem_strobes_exclusive: assert property (@(posedge clk) disable iff (rst)
    !(pmem_read && pmem_write));

endmodule

// File: tb/tb_eviction_writeback_ctrl.sv
// Bench for eviction_writeback_ctrl: scripted cycle table, directed corner sequences,
// then random cache/pmem traffic checked against a line-coherence model.
module tb_eviction_writeback_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, evict_req, mem_read, pmem_resp;
  logic [11:0]  evict_addr, mem_addr;
  logic [127:0] evict_data, pmem_rdata;
  logic         evict_ack, mem_resp, evb_load, pmem_read, pmem_write, wb_idle;
  logic [127:0] mem_rdata, pmem_wdata;
  logic [15:0]  pmem_address, wb_count;
  logic [11:0]  evb_addr;
  logic [127:0] evb_data;

  int vec_n = 0;
  int miss_n = 0;

  eviction_writeback_ctrl dut (
    .clk(clk), .rst(rst),
    .evict_req(evict_req), .evict_addr(evict_addr), .evict_data(evict_data), .evict_ack(evict_ack),
    .mem_read(mem_read), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
    .evb_load(evb_load), .evb_addr(evb_addr), .evb_data(evb_data),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
    .wb_idle(wb_idle), .wb_count(wb_count)
  );

  // The parent's eviction buffer: unreset storage loaded on evb_load.
  always @(posedge clk) begin
    if (evb_load) begin
      evb_addr <= evict_addr;
      evb_data <= evict_data;
    end
  end

  function automatic logic [127:0] line_data(input logic [11:0] a);
    return {8{4'hA, a}};
  endfunction

  function automatic logic [127:0] fill_data(input logic [11:0] a);
    return {8{4'hD, a}};
  endfunction

  task automatic chk1(input string name, input logic act, input logic exp);
    vec_n++;
    if (act !== exp) begin
      miss_n++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    vec_n++;
    if (act !== exp) begin
      miss_n++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk128(input string name, input logic [127:0] act, input logic [127:0] exp);
    vec_n++;
    if (act !== exp) begin
      miss_n++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic er, input logic [11:0] ea, input logic mr,
                       input logic [11:0] ma, input logic pr);
    evict_req  = er;
    evict_addr = ea;
    evict_data = line_data(ea);
    mem_read   = mr;
    mem_addr   = ma;
    pmem_resp  = pr;
    pmem_rdata = fill_data(ma);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b0, 12'h000, 1'b0, 12'h000, 1'b0);
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    next_cycle();
  endtask

  // Scripted cycles: evict+miss together, then a parked-line hit.
  typedef struct packed {
    logic [2:0]  in_f;   // {evict_req, mem_read, pmem_resp}
    logic [11:0] ea;
    logic [11:0] ma;
    logic [5:0]  exp_f;  // {evict_ack, pmem_read, pmem_write, mem_resp, hit_data, wb_idle}
    logic [15:0] paddr;
    logic [15:0] cnt;
  } vec_t;

  vec_t tbl [12];

  // Random-phase model state.
  logic [127:0] golden     [logic [11:0]];
  logic [127:0] pmem_store [logic [11:0]];
  bit           rd_on, ev_on, pm_busy, pm_wr;
  int           pm_cnt, outstanding, accepted, wb_done;
  logic [11:0]  rd_a, ev_a, pm_a;
  logic [127:0] ev_d;

  function automatic logic [127:0] golden_of(input logic [11:0] a);
    return golden.exists(a) ? golden[a] : fill_data(a);
  endfunction

  function automatic logic [127:0] pm_lookup(input logic [11:0] a);
    return pmem_store.exists(a) ? pmem_store[a] : fill_data(a);
  endfunction

  function automatic logic [11:0] pick_line();
    return 12'h400 | 12'($urandom_range(0, 15));
  endfunction

  task automatic rand_cycle(input bit allow_new);
    if (allow_new && !rd_on && $urandom_range(0, 3) == 0) begin
      rd_on = 1'b1;
      rd_a  = pick_line();
      if (ev_on && rd_a == ev_a) rd_a = rd_a ^ 12'h001;
    end
    if (allow_new && !ev_on && $urandom_range(0, 3) == 0) begin
      ev_on = 1'b1;
      ev_a  = pick_line();
      if (rd_on && ev_a == rd_a) ev_a = ev_a ^ 12'h001;
      ev_d  = {$urandom, $urandom, $urandom, $urandom};
    end
    pmem_resp = 1'b0;
    if (pm_busy) begin
      if (pm_cnt == 0) begin
        pmem_resp  = 1'b1;
        pmem_rdata = pm_lookup(pm_a);
      end else begin
        pm_cnt--;
      end
    end
    evict_req  = ev_on;
    evict_addr = ev_a;
    evict_data = ev_d;
    mem_read   = rd_on;
    mem_addr   = rd_a;
    @(negedge clk);
    chk1("r_strobe_excl", pmem_read & pmem_write, 1'b0);
    if (pm_busy) begin
      chk1("r_strobe_hold", pm_wr ? pmem_write : pmem_read, 1'b1);
      chk16("r_addr_hold", pmem_address, {pm_a, 4'h0});
    end
    chk1("r_ack", evict_ack, ev_on && outstanding == 0);
    chk1("r_load", evb_load, ev_on && outstanding == 0);
    chk16("r_wb_count", wb_count, 16'(wb_done));
    if (outstanding > 0) chk1("r_idle_busy", wb_idle, 1'b0);
    else if (!pmem_read) chk1("r_idle_free", wb_idle, 1'b1);
    if (mem_resp) begin
      chk1("r_resp_requested", rd_on, 1'b1);
      chk128("r_rdata", mem_rdata, golden_of(rd_a));
      rd_on = 1'b0;
    end
    if (pm_busy && pmem_resp) begin
      if (pm_wr) begin
        chk128("r_wdata", pmem_wdata, golden_of(pm_a));
        pmem_store[pm_a] = pmem_wdata;
        wb_done++;
        outstanding--;
      end
      pm_busy = 1'b0;
    end else if (!pm_busy && (pmem_read || pmem_write)) begin
      chk16("r_addr_offset", pmem_address & 16'h000F, 16'h0000);
      pm_busy = 1'b1;
      pm_wr   = pmem_write;
      pm_a    = pmem_address[15:4];
      pm_cnt  = $urandom_range(0, 4);
    end
    if (evict_ack) begin
      golden[ev_a] = ev_d;
      outstanding++;
      accepted++;
      ev_on = 1'b0;
    end
    next_cycle();
  endtask

  initial begin
    tbl[0]  = '{3'b110, 12'h011, 12'h022, 6'b100001, 16'h0000, 16'd0};
    tbl[1]  = '{3'b010, 12'h000, 12'h022, 6'b010000, 16'h0220, 16'd0};
    tbl[2]  = '{3'b011, 12'h000, 12'h022, 6'b010100, 16'h0220, 16'd0};
    tbl[3]  = '{3'b000, 12'h000, 12'h000, 6'b000000, 16'h0000, 16'd0};
    tbl[4]  = '{3'b000, 12'h000, 12'h000, 6'b001000, 16'h0110, 16'd0};
    tbl[5]  = '{3'b001, 12'h000, 12'h000, 6'b001000, 16'h0110, 16'd0};
    tbl[6]  = '{3'b000, 12'h000, 12'h000, 6'b000001, 16'h0000, 16'd1};
    tbl[7]  = '{3'b100, 12'h055, 12'h000, 6'b100001, 16'h0000, 16'd1};
    tbl[8]  = '{3'b010, 12'h000, 12'h055, 6'b000110, 16'h0000, 16'd1};
    tbl[9]  = '{3'b000, 12'h000, 12'h000, 6'b000000, 16'h0000, 16'd1};
    tbl[10] = '{3'b001, 12'h000, 12'h000, 6'b001000, 16'h0550, 16'd1};
    tbl[11] = '{3'b000, 12'h000, 12'h000, 6'b000001, 16'h0000, 16'd2};

    // Reset cycle and the cycle after: all quiet even with an eviction pending.
    drive(1'b1, 12'h0F0, 1'b0, 12'h000, 1'b0);
    rst = 1'b1;
    next_cycle();
    @(negedge clk);
    chk1("rst_ack", evict_ack, 1'b0);
    chk1("rst_load", evb_load, 1'b0);
    chk1("rst_resp", mem_resp, 1'b0);
    chk1("rst_pread", pmem_read, 1'b0);
    chk1("rst_pwrite", pmem_write, 1'b0);
    chk16("rst_paddr", pmem_address, 16'h0000);
    chk16("rst_count", wb_count, 16'h0000);
    chk1("rst_idle", wb_idle, 1'b1);
    chk128("rst_wdata", pmem_wdata, 128'h0);
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    chk1("post_rst_ack", evict_ack, 1'b0);
    chk1("post_rst_pwrite", pmem_write, 1'b0);
    chk1("post_rst_idle", wb_idle, 1'b1);
    chk16("post_rst_count", wb_count, 16'h0000);
    next_cycle();
    drive(1'b0, 12'h000, 1'b0, 12'h000, 1'b0);
    @(negedge clk);
    chk1("post_rst2_idle", wb_idle, 1'b1);
    chk1("post_rst2_ack", evict_ack, 1'b0);
    next_cycle();

    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].in_f[2], tbl[i].ea, tbl[i].in_f[1], tbl[i].ma, tbl[i].in_f[0]);
      @(negedge clk);
      chk1($sformatf("tbl%0d_ack", i), evict_ack, tbl[i].exp_f[5]);
      chk1($sformatf("tbl%0d_load", i), evb_load, tbl[i].exp_f[5]);
      chk1($sformatf("tbl%0d_pread", i), pmem_read, tbl[i].exp_f[4]);
      chk1($sformatf("tbl%0d_pwrite", i), pmem_write, tbl[i].exp_f[3]);
      chk1($sformatf("tbl%0d_resp", i), mem_resp, tbl[i].exp_f[2]);
      chk1($sformatf("tbl%0d_idle", i), wb_idle, tbl[i].exp_f[0]);
      chk16($sformatf("tbl%0d_paddr", i), pmem_address, tbl[i].paddr);
      chk16($sformatf("tbl%0d_count", i), wb_count, tbl[i].cnt);
      if (tbl[i].exp_f[2])
        chk128($sformatf("tbl%0d_rdata", i), mem_rdata,
               tbl[i].exp_f[1] ? line_data(tbl[i].ma) : fill_data(tbl[i].ma));
      if (tbl[i].exp_f[3])
        chk128($sformatf("tbl%0d_wdata", i), pmem_wdata, line_data(tbl[i].paddr[15:4]));
      next_cycle();
    end

    // Plain miss with a 5-cycle pmem.
    do_reset();
    drive(1'b0, 12'h000, 1'b1, 12'h0A3, 1'b0);
    @(negedge clk);
    chk1("miss_c0_pread", pmem_read, 1'b0);
    next_cycle();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk1("miss_wait_pread", pmem_read, 1'b1);
      chk16("miss_wait_paddr", pmem_address, 16'h0A30);
      chk1("miss_wait_resp", mem_resp, 1'b0);
      next_cycle();
    end
    pmem_resp  = 1'b1;
    pmem_rdata = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_CAFE_F00D;
    @(negedge clk);
    chk1("miss_resp", mem_resp, 1'b1);
    chk128("miss_rdata", mem_rdata, 128'hDEAD_BEEF_0123_4567_89AB_CDEF_CAFE_F00D);
    next_cycle();
    drive(1'b0, 12'h000, 1'b0, 12'h000, 1'b0);
    @(negedge clk);
    chk1("miss_after_resp", mem_resp, 1'b0);
    chk1("miss_after_pread", pmem_read, 1'b0);
    chk16("miss_count", wb_count, 16'd0);
    chk1("miss_idle", wb_idle, 1'b1);
    next_cycle();

    // Back-to-back evictions: the second waits for the first writeback.
    drive(1'b1, 12'h100, 1'b0, 12'h000, 1'b0);
    @(negedge clk);
    chk1("b2b_first_ack", evict_ack, 1'b1);
    next_cycle();
    drive(1'b1, 12'h101, 1'b0, 12'h000, 1'b0);
    @(negedge clk);
    chk1("b2b_stall_c1", evict_ack, 1'b0);
    next_cycle();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk1("b2b_stall_wr", evict_ack, 1'b0);
      chk1("b2b_pwrite", pmem_write, 1'b1);
      chk16("b2b_paddr", pmem_address, 16'h1000);
      next_cycle();
    end
    pmem_resp = 1'b1;
    @(negedge clk);
    chk1("b2b_stall_resp", evict_ack, 1'b0);
    chk128("b2b_wdata", pmem_wdata, line_data(12'h100));
    next_cycle();
    pmem_resp = 1'b0;
    @(negedge clk);
    chk1("b2b_second_ack", evict_ack, 1'b1);
    chk16("b2b_count", wb_count, 16'd1);
    next_cycle();

    // A fill raised mid-write waits until the write completes.
    drive(1'b0, 12'h000, 1'b0, 12'h000, 1'b0);
    @(negedge clk);
    chk1("rdw_c0_pwrite", pmem_write, 1'b0);
    next_cycle();
    drive(1'b0, 12'h000, 1'b1, 12'h200, 1'b0);
    @(negedge clk);
    chk1("rdw_c1_pwrite", pmem_write, 1'b1);
    chk1("rdw_c1_pread", pmem_read, 1'b0);
    chk1("rdw_c1_resp", mem_resp, 1'b0);
    next_cycle();
    pmem_resp = 1'b1;
    @(negedge clk);
    chk1("rdw_c2_pwrite", pmem_write, 1'b1);
    chk1("rdw_c2_pread", pmem_read, 1'b0);
    chk1("rdw_c2_resp", mem_resp, 1'b0);
    chk128("rdw_c2_wdata", pmem_wdata, line_data(12'h101));
    next_cycle();
    pmem_resp = 1'b0;
    @(negedge clk);
    chk1("rdw_c3_pread", pmem_read, 1'b0);
    chk1("rdw_c3_pwrite", pmem_write, 1'b0);
    chk16("rdw_c3_count", wb_count, 16'd2);
    next_cycle();
    @(negedge clk);
    chk1("rdw_c4_pread", pmem_read, 1'b1);
    chk1("rdw_c4_pwrite", pmem_write, 1'b0);
    chk16("rdw_c4_paddr", pmem_address, 16'h2000);
    next_cycle();
    pmem_resp = 1'b1;
    @(negedge clk);
    chk1("rdw_c5_resp", mem_resp, 1'b1);
    chk128("rdw_c5_rdata", mem_rdata, fill_data(12'h200));
    next_cycle();

    // Reset while writing discards the parked line.
    drive(1'b1, 12'h300, 1'b0, 12'h000, 1'b0);
    @(negedge clk);
    chk1("rmw_ack", evict_ack, 1'b1);
    next_cycle();
    drive(1'b0, 12'h000, 1'b0, 12'h000, 1'b0);
    next_cycle();
    @(negedge clk);
    chk1("rmw_pwrite_before", pmem_write, 1'b1);
    next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk1("rmw_pwrite_after", pmem_write, 1'b0);
      chk1("rmw_idle_after", wb_idle, 1'b1);
      chk16("rmw_count_after", wb_count, 16'd0);
      next_cycle();
    end

    // Random traffic against the coherence model.
    do_reset();
    rd_on = 1'b0; ev_on = 1'b0; pm_busy = 1'b0; pm_wr = 1'b0;
    pm_cnt = 0; outstanding = 0; accepted = 0; wb_done = 0;
    rd_a = 12'h400; ev_a = 12'h401; pm_a = 12'h000; ev_d = '0;
    for (int c = 0; c < 2500; c++) rand_cycle(1'b1);
    for (int c = 0; c < 300 && (rd_on || ev_on || pm_busy || outstanding > 0); c++)
      rand_cycle(1'b0);
    chk1("drain_complete", rd_on || ev_on || pm_busy || outstanding > 0, 1'b0);
    drive(1'b0, 12'h000, 1'b0, 12'h000, 1'b0);
    @(negedge clk);
    chk16("final_count", wb_count, 16'(accepted));
    chk1("final_idle", wb_idle, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_n, miss_n);
    $finish;
  end

endmodule

// File: doc/eviction_writeback_ctrl.md
Name: eviction_writeback_ctrl

Overview:
- Control stage that drives and drains the dirty-line eviction buffer sitting between the cache controller and physical memory.
- Accepts dirty-line evictions from the cache and parks them in the eviction buffer, so the pending miss read proceeds first.
- Writes the parked line back to pmem when the memory port is otherwise idle.
- Serves reads that hit the parked line directly from the buffer, with no pmem access.

Parameters:
LINE_ADDR_W, 12, line address width (byte address = {line_addr, OFFSET_W zeros})
OFFSET_W, 4, byte-offset bits within a line
DATA_W, 128, cache line width in bits

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
evict_req  in  1  cache requests to park a dirty line
evict_addr  in  LINE_ADDR_W  line address of the evicted line
evict_data  in  DATA_W  evicted line data
evict_ack  out  1  eviction accepted this cycle
mem_read  in  1  cache line-fill request, held until mem_resp
mem_addr  in  LINE_ADDR_W  line address to fill
mem_rdata  out  DATA_W  fill data, valid when mem_resp
mem_resp  out  1  fill complete, 1-cycle pulse
evb_load  out  1  load strobe to eviction buffer
evb_addr  in  LINE_ADDR_W  eviction buffer stored address
evb_data  in  DATA_W  eviction buffer stored data
pmem_read  out  1  physical memory read
pmem_write  out  1  physical memory write
pmem_address  out  LINE_ADDR_W+OFFSET_W  physical byte address, offset bits zero
pmem_wdata  out  DATA_W  equals evb_data
pmem_rdata  in  DATA_W  physical memory read data
pmem_resp  in  1  physical memory done, 1-cycle pulse
wb_idle  out  1  state IDLE and buf_valid=0 (safe to halt/flush)
wb_count  out  16  saturating count of completed writebacks

Behaviour:
- Reset: state=IDLE, buf_valid=0, wb_count=0.
- Every output is 0 during the reset cycle and the cycle after, except wb_idle=1.
- The eviction buffer has no reset; buf_valid masks its contents.
- States: IDLE, READ, WRITE.
- Eviction accept, combinational: evict_ack=evb_load=evict_req & ~buf_valid & (state!=WRITE).
  - On accept, the buffer captures evict_addr/evict_data at that edge and buf_valid<=1.
  - While buf_valid=1, evict_req stalls (ack=0) until the writeback completes.
- IDLE, priority 1, buffer hit: mem_read & buf_valid & mem_addr==evb_addr.
  - Same cycle: mem_resp=1, mem_rdata=evb_data, zero latency, no pmem access.
  - State stays IDLE.
- IDLE, priority 2, mem_read otherwise: next state READ.
- IDLE, priority 3, no mem_read & buf_valid: next state WRITE.
- READ:
  - pmem_read=1, pmem_address={mem_addr, 0}.
  - On pmem_resp: mem_resp=1 and mem_rdata=pmem_rdata in the same cycle, then IDLE.
  - Total miss latency = pmem latency + 1 cycle.
- WRITE:
  - pmem_write=1, pmem_address={evb_addr, 0}, pmem_wdata=evb_data.
  - On pmem_resp: buf_valid<=0, wb_count increments (saturates at 16'hFFFF), then IDLE.
  - Not preemptible: a mem_read arriving during WRITE waits for IDLE.
- Simultaneous evict_req and mem_read in IDLE with buf_valid=0:
  - Eviction is accepted.
  - Read hit compare uses pre-load buffer contents (no hit); READ is entered.
  - The writeback follows the read.
- mem_read to the line being evicted in the same cycle is a protocol violation; assertion required.
- pmem_read and pmem_write are never both 1. pmem_resp outside READ/WRITE is ignored.
- Reset during READ/WRITE: strobes drop the next cycle and the parked line is discarded.
  - The caller must not reset with dirty data it needs.

Decomposition:
- Shared cache package holds:
  - state enum wb_state_t {IDLE, READ, WRITE}
  - LINE_ADDR_W, OFFSET_W, DATA_W
  - line-to-byte address helper function
- No sub-module. The existing eviction buffer is instantiated alongside by the parent, not inside this block.

Test Plan:
- Miss, no eviction: mem_read addr 12'h0A3, pmem_resp after 5 cycles with 128'hDEAD... -> pmem_address=16'h0A30, mem_resp 1 pulse carrying that data, wb_count=0.
- Evict then miss: evict 12'h011 / data A, then mem_read 12'h022.
  - Required: ack in cycle 0, read 16'h0220 completes first.
  - Then pmem_write 16'h0110 with data A; wb_count=1; wb_idle=1 afterwards.
- Buffer hit: park 12'h055 / data B, then mem_read 12'h055 before the writeback starts -> same-cycle mem_resp with B, no pmem_read.
- Back-to-back evictions: second evict_req held -> ack=0 until first writeback pmem_resp, acked in the IDLE cycle after.
- Read during WRITE: mem_read raised mid-write -> pmem_read only after pmem_write's resp. Strobes are never concurrent.
- Reset mid-WRITE: rst asserted -> next cycle pmem_write=0, buf_valid=0, wb_idle=1, wb_count=0.
